uart_rx_drv: RTL and testbench

UART_RX_DRV -- requirements
Module: uart_rx_drv

---
 rtl/tester_pkg.sv | 16 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_drv.sv | 132 +++++++++++++
 tb/tb_uart_rx_drv.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tester_pkg.sv
// tester_pkg: shared UART receiver state encoding and constants.
package tester_pkg;
    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 234;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx_drv.sv
// uart_rx_drv: 8N1 UART receiver with mid-bit sampling and framing-error pulse.
// Define UART_RX_PARITY_EN to receive an extra even-parity bit (8E1).
module uart_rx_drv
    import tester_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_rx,
    output logic [UART_DATA_W-1:0] out_data,
    output logic                   out_valid,
    output logic                   out_frame_err,
    output logic                   out_busy
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_W);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_W - 1);

    logic                   rx_s;
    uart_rx_state_e         state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   tick_done;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk(in_clk),
        .rst(in_rst),
        .d  (in_rx),
        .q  (rx_s)
    );

    assign tick_done = tick_q == TICK_LAST;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + TW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (!rx_s) state_d = START;
            end
            // One cycle past the half-bit count puts the sample mid start bit.
            START: if (tick_q == TICK_HALF) begin
                tick_d  = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (tick_done) begin
                tick_d  = '0;
                shift_d = {rx_s, shift_q[UART_DATA_W-1:1]};
                bit_d   = bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
                if (bit_q == BIT_LAST) state_d = PARITY;
`else
                if (bit_q == BIT_LAST) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick_done) begin
                tick_d    = '0;
                par_err_d = rx_s ^ (^shift_q);
                state_d   = STOP;
            end
`endif
            STOP: if (tick_done) begin
                tick_d  = '0;
                state_d = rx_s ? IDLE : WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                ferr_d  = !rx_s || par_err_q;
`else
                ferr_d  = !rx_s;
`endif
                valid_d = !ferr_d;
                data_d  = ferr_d ? data_q : shift_q;
            end
            WAIT_HIGH: begin
                tick_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign out_frame_err = ferr_q;
    assign out_busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_drv.sv
// tb_uart_rx_drv: directed frame table, glitch/reset sequences and random frames
// checked against an event-timing reference model.
module tb_uart_rx_drv;
    localparam int C = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = 2 + C / 2 + (9 + PB) * C + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, ferr, busy;

    uart_rx_drv #(.CLKS_PER_BIT(C)) dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_rx        (rx),
        .out_data     (data),
        .out_valid    (valid),
        .out_frame_err(ferr),
        .out_busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par_bad;
        int         hold;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } frame_t;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    frame_t     vec[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_byte;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (valid || ferr) begin
            got_q.push_back('{cyc, ferr, data});
            chk("valid_err_exclusive", {31'd0, valid && ferr}, 32'd0);
        end
    end

    // Drives one frame starting at a falling clock edge; the expected pulse
    // lands LAT edges after the first edge that sees the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                              input int hold, input int gap,
                              input logic exp_err, input logic [7:0] exp_data);
        int t0 = cyc + 1;
        exp_q.push_back('{t0 + LAT, exp_err, exp_data});
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) @(negedge clk);
        end
        if (PB != 0) begin
            rx = (^d) ^ par_bad;
            repeat (C) @(negedge clk);
        end
        rx = stop;
        repeat (C + (stop ? 0 : hold)) @(negedge clk);
        if (!stop) chk("wait_high_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
        if (!stop && gap >= 4) chk("wait_high_exit", {31'd0, busy}, 32'd0);
    endtask

    task automatic compare_events(input string tag);
        int n;
        repeat (2 * C) @(negedge clk);
        chk($sformatf("%s_event_count", tag), got_q.size(), exp_q.size());
        n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_ev%0d_cycle", tag, i), got_q[i].cyc, exp_q[i].cyc);
            chk($sformatf("%s_ev%0d_err", tag, i), {31'd0, got_q[i].err}, {31'd0, exp_q[i].err});
            chk($sformatf("%s_ev%0d_data", tag, i), {24'd0, got_q[i].data}, {24'd0, exp_q[i].data});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec.push_back('{8'h55, 1'b1, 1'b0, 0, 6, 1'b0, 8'h55});
        vec.push_back('{8'hA3, 1'b0, 1'b0, 32, 10, 1'b1, 8'h55});
        vec.push_back('{8'h01, 1'b1, 1'b0, 0, 0, 1'b0, 8'h01});
        vec.push_back('{8'hFF, 1'b1, 1'b0, 0, 0, 1'b0, 8'hFF});
        vec.push_back('{8'h80, 1'b1, 1'b0, 0, 10, 1'b0, 8'h80});
`ifdef UART_RX_PARITY_EN
        vec.push_back('{8'h07, 1'b1, 1'b0, 0, 10, 1'b0, 8'h07});
        vec.push_back('{8'h07, 1'b1, 1'b1, 0, 10, 1'b1, 8'h07});
`endif

        repeat (4) @(negedge clk);
        chk("reset_data", {24'd0, data}, 32'h00);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_frame_err", {31'd0, ferr}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        foreach (vec[i])
            send_frame(vec[i].d, vec[i].stop, vec[i].par_bad, vec[i].hold, vec[i].gap,
                       vec[i].exp_err, vec[i].exp_data);
        compare_events("table");

        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        repeat (6) @(negedge clk);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        compare_events("glitch");

        begin
            logic [7:0] d = 8'h3C;
            rx = 1'b0;
            repeat (C) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rx = d[i];
                repeat (C) @(negedge clk);
            end
            rx = d[4];
            repeat (C / 2) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            chk("midrst_data", {24'd0, data}, 32'h00);
            chk("midrst_valid", {31'd0, valid}, 32'd0);
            chk("midrst_frame_err", {31'd0, ferr}, 32'd0);
            chk("midrst_busy", {31'd0, busy}, 32'd0);
            rst = 1'b0;
            rx  = 1'b1;
            repeat (2 * C) @(negedge clk);
            send_frame(8'h7E, 1'b1, 1'b0, 0, 4, 1'b0, 8'h7E);
            compare_events("midrst");
        end

        last_byte = 8'h7E;
        for (int n = 0; n < 25; n++) begin
            logic [7:0] d    = 8'($urandom);
            logic       stop = $urandom_range(0, 5) != 0;
            logic       pb   = (PB != 0) && ($urandom_range(0, 5) == 0);
            int         hold = $urandom_range(0, 24);
            int         gap  = stop ? $urandom_range(0, 12) : $urandom_range(4, 12);
            logic       good = stop && !pb;
            send_frame(d, stop, pb, hold, gap, !good, good ? d : last_byte);
            if (good) last_byte = d;
        end
        compare_events("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
